// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg
// Shared definitions for the BRAM request controller:
//   - ST_* state encodings and the state_e enum built from them (3 bits)
//   - CNT_WIDTH, width of the optional activity counters
//     (used when BRAM_CTRL_COUNTERS_EN is defined)
package bram_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ_WAIT = 3'd1;
  localparam logic [2:0] ST_RESP_HOLD = 3'd2;
  localparam logic [2:0] ST_RMW_READ  = 3'd3;
  localparam logic [2:0] ST_RMW_WRITE = 3'd4;

  localparam int CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_READ_WAIT = ST_READ_WAIT,
    S_RESP_HOLD = ST_RESP_HOLD,
    S_RMW_READ  = ST_RMW_READ,
    S_RMW_WRITE = ST_RMW_WRITE
  } state_e;

endpackage

// File: rtl/bram_byte_merge.sv
// bram_byte_merge
// Combinational byte merge for read-modify-write: each byte lane takes the
// write data when its mask bit is set, otherwise keeps the word read from BRAM.
// Ports:
//   wdata  in  DATA_WIDTH    new write data
//   rdata  in  DATA_WIDTH    current BRAM contents
//   mask   in  DATA_WIDTH/8  byte enables (1 = take wdata byte)
//   merged out DATA_WIDTH    merged word
module bram_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [DATA_WIDTH/8-1:0] mask,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Per-byte mux of write data over read data
  always_comb begin
    merged = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (mask[i]) begin
        merged[i*8 +: 8] = wdata[i*8 +: 8];
      end else begin
        merged[i*8 +: 8] = rdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/bram_request_controller.sv
// bram_request_controller
// Initiator side of a BRAM port pair. Accepts word requests over valid/ready,
// drives the BRAM read/write ports, hides the one-cycle read latency and
// returns read data over a valid/ready response channel. Partial-mask writes
// are done as read-modify-write (read, merge, write: 3 cycles to IDLE).
// Ports:
//   clock, reset (sync, active-low)
//   req_valid/req_ready/req_write/req_address/req_data/req_byte_en  request
//   resp_valid/resp_ready/resp_data                                 response
//   bram_readEnable/bram_readAddress/bram_readData                  BRAM read
//   bram_writeEnable/bram_writeAddress/bram_writeData               BRAM write
// Optional: define BRAM_CTRL_COUNTERS_EN to add read_count/write_count
// (saturating counts of accepted reads and issued BRAM writes).
module bram_request_controller
  import bram_ctrl_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 8,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [BE_WIDTH-1:0]   req_byte_en,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  bram_readEnable,
  output logic [ADDR_WIDTH-1:0] bram_readAddress,
  input  logic [DATA_WIDTH-1:0] bram_readData,
  output logic                  bram_writeEnable,
  output logic [ADDR_WIDTH-1:0] bram_writeAddress,
  output logic [DATA_WIDTH-1:0] bram_writeData
`ifdef BRAM_CTRL_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]  read_count,
  output logic [CNT_WIDTH-1:0]  write_count
`endif
);

  state_e                state_q,  state_d;
  logic [DATA_WIDTH-1:0] hold_q,   hold_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [BE_WIDTH-1:0]   mask_q,   mask_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;

  logic [DATA_WIDTH-1:0] merge_s;
  logic                  can_accept_s;
  logic                  read_accept_s;

  bram_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .wdata  (wdata_q),
    .rdata  (bram_readData),
    .mask   (mask_q),
    .merged (merge_s)
  );

  // Next-state, datapath updates and all combinational outputs
  always_comb begin
    state_d           = state_q;
    hold_d            = hold_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    mask_d            = mask_q;
    merged_d          = merged_q;
    can_accept_s      = 1'b0;
    read_accept_s     = 1'b0;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_data         = '0;
    bram_readEnable   = 1'b0;
    bram_readAddress  = addr_q;
    bram_writeEnable  = 1'b0;
    bram_writeAddress = addr_q;
    bram_writeData    = merged_q;

    case (state_q)
      S_IDLE: begin
        can_accept_s = 1'b1;
      end
      S_READ_WAIT: begin
        // Read data arrives this cycle; pass it straight through
        resp_valid = 1'b1;
        resp_data  = bram_readData;
        if (resp_ready) begin
          can_accept_s = 1'b1;
          state_d      = S_IDLE;
        end else begin
          // BRAM output only lasts a cycle, so park it for the stalled consumer
          hold_d  = bram_readData;
          state_d = S_RESP_HOLD;
        end
      end
      S_RESP_HOLD: begin
        resp_valid = 1'b1;
        resp_data  = hold_q;
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP_HOLD;
        end
      end
      S_RMW_READ: begin
        merged_d = merge_s;
        state_d  = S_RMW_WRITE;
      end
      S_RMW_WRITE: begin
        bram_writeEnable = 1'b1;
        state_d          = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request acceptance is shared by IDLE and a READ_WAIT whose response drains
    if (can_accept_s) begin
      req_ready = 1'b1;
      if (req_valid) begin
        if (!req_write) begin
          read_accept_s    = 1'b1;
          bram_readEnable  = 1'b1;
          bram_readAddress = req_address;
          state_d          = S_READ_WAIT;
        end else if (&req_byte_en) begin
          bram_writeEnable  = 1'b1;
          bram_writeAddress = req_address;
          bram_writeData    = req_data;
        end else if (req_byte_en == '0) begin
          state_d = state_d;
        end else begin
          addr_d           = req_address;
          wdata_d          = req_data;
          mask_d           = req_byte_en;
          bram_readEnable  = 1'b1;
          bram_readAddress = req_address;
          state_d          = S_RMW_READ;
        end
      end else begin
        state_d = state_d;
      end
    end else begin
      state_d = state_d;
    end

    // Reset abandons everything: no handshake, no BRAM access, no response
    if (!reset) begin
      req_ready        = 1'b0;
      read_accept_s    = 1'b0;
      resp_valid       = 1'b0;
      resp_data        = '0;
      bram_readEnable  = 1'b0;
      bram_writeEnable = 1'b0;
    end else begin
      resp_valid = resp_valid;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      merged_q <= merged_d;
    end
  end

`ifdef BRAM_CTRL_COUNTERS_EN
  logic [CNT_WIDTH-1:0] read_count_q,  read_count_d;
  logic [CNT_WIDTH-1:0] write_count_q, write_count_d;

  // Saturating activity counters
  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    if (read_accept_s && (read_count_q != '1)) begin
      read_count_d = read_count_q + CNT_WIDTH'(1);
    end else begin
      read_count_d = read_count_q;
    end
    if (bram_writeEnable && (write_count_q != '1)) begin
      write_count_d = write_count_q + CNT_WIDTH'(1);
    end else begin
      write_count_d = write_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_bram_request_controller.sv
// Self-checking bench for bram_request_controller with a behavioural BRAM.
// ref_mem is the bench's own view of memory contents; expected read data is
// pushed to exp_q on each accepted read and popped when the response appears.
module tb_bram_request_controller;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = DW / 8;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic [BW-1:0] req_byte_en;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          bram_readEnable;
  logic [AW-1:0] bram_readAddress;
  logic [DW-1:0] bram_readData;
  logic          bram_writeEnable;
  logic [AW-1:0] bram_writeAddress;
  logic [DW-1:0] bram_writeData;
`ifdef BRAM_CTRL_COUNTERS_EN
  logic [31:0]   read_count;
  logic [31:0]   write_count;
`endif

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q   [$];
  logic [DW-1:0] exp_v;
  int            writes_seen;
  int            wbase;
  int            errors;
  int            checks;

  bram_request_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_data          (req_data),
    .req_byte_en       (req_byte_en),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .bram_readEnable   (bram_readEnable),
    .bram_readAddress  (bram_readAddress),
    .bram_readData     (bram_readData),
    .bram_writeEnable  (bram_writeEnable),
    .bram_writeAddress (bram_writeAddress),
    .bram_writeData    (bram_writeData)
`ifdef BRAM_CTRL_COUNTERS_EN
    ,
    .read_count        (read_count),
    .write_count       (write_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM model: registered read, synchronous write
  always @(posedge clock) begin
    if (bram_readEnable) bram_readData <= mem[bram_readAddress];
    if (bram_writeEnable) begin
      mem[bram_writeAddress] <= bram_writeData;
      writes_seen <= writes_seen + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_address = 8'h00;
    req_data = 32'h0; req_byte_en = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'h10;
    req_data = 32'h0; req_byte_en = 4'h0;
    tick(); tick(); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (bram_readEnable !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b expected 0", bram_readEnable); end
    checks++; if (bram_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", bram_writeEnable); end
    checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp: got %b/%h expected 0/0", resp_valid, resp_data); end
    tick(); reset = 1'b1; idle_inputs(); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_read_latency();
    tick(); resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'h10; #1;
    checks++; if (req_ready !== 1'b1 || bram_readEnable !== 1'b1 || bram_readAddress !== 8'h10) begin
      errors++; $display("FAIL lat_issue: got rdy=%b en=%b addr=%h expected 1 1 10", req_ready, bram_readEnable, bram_readAddress); end
    exp_q.push_back(ref_mem[8'h10]);
    tick(); idle_inputs(); #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL lat_resp: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
    tick(); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL lat_idle: got v=%b rdy=%b expected 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      req_valid = 1'b1; req_write = 1'b0; req_address = AW'(i + 1); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, req_ready); end
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
          errors++; $display("FAIL b2b_resp%0d: got v=%b d=%h expected 1 %h", i, resp_valid, resp_data, exp_v); end
      end
      exp_q.push_back(ref_mem[i + 1]);
    end
    tick(); idle_inputs(); #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL b2b_last: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
    tick(); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", resp_valid); end
  endtask

  task automatic test_backpressure();
    tick(); resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'h05; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", req_ready); end
    exp_q.push_back(ref_mem[8'h05]);
    for (int c = 0; c < 4; c++) begin
      tick(); req_address = 8'h06; #1;
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp_q[0] || req_ready !== 1'b0 || bram_readEnable !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b en=%b expected 1 %h 0 0", c, resp_valid, resp_data, req_ready, bram_readEnable, exp_q[0]); end
    end
    tick(); resp_ready = 1'b1; #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v || req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_xfer: got v=%b d=%h rdy=%b expected 1 %h 0", resp_valid, resp_data, req_ready, exp_v); end
    tick(); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bram_readEnable !== 1'b1) begin
      errors++; $display("FAIL bp_single: got v=%b rdy=%b en=%b expected 0 1 1", resp_valid, req_ready, bram_readEnable); end
    exp_q.push_back(ref_mem[8'h06]);
    tick(); idle_inputs(); #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL bp_next: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
  endtask

  task automatic test_rmw();
    logic [DW-1:0] wd;
    logic [BW-1:0] m;
    wd = 32'h11223344; m = 4'b0101;
    tick(); resp_ready = 1'b1; wbase = writes_seen;
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'h20; req_data = wd; req_byte_en = m; #1;
    checks++; if (req_ready !== 1'b1 || bram_readEnable !== 1'b1 || bram_readAddress !== 8'h20 || bram_writeEnable !== 1'b0) begin
      errors++; $display("FAIL rmw_read_issue: got rdy=%b ren=%b ra=%h wen=%b expected 1 1 20 0", req_ready, bram_readEnable, bram_readAddress, bram_writeEnable); end
    for (int b = 0; b < BW; b++) if (m[b]) ref_mem[8'h20][b*8 +: 8] = wd[b*8 +: 8];
    tick(); idle_inputs(); #1;
    checks++; if (req_ready !== 1'b0 || bram_readEnable !== 1'b0 || bram_writeEnable !== 1'b0) begin
      errors++; $display("FAIL rmw_merge_cycle: got rdy=%b ren=%b wen=%b expected 0 0 0", req_ready, bram_readEnable, bram_writeEnable); end
    tick(); #1;
    checks++; if (bram_writeEnable !== 1'b1 || bram_writeAddress !== 8'h20 || bram_writeData !== ref_mem[8'h20] || req_ready !== 1'b0) begin
      errors++; $display("FAIL rmw_write: got wen=%b wa=%h wd=%h rdy=%b expected 1 20 %h 0", bram_writeEnable, bram_writeAddress, bram_writeData, req_ready, ref_mem[8'h20]); end
    tick(); req_valid = 1'b1; req_write = 1'b0; req_address = 8'h20; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_idle: got %b expected 1", req_ready); end
    exp_q.push_back(ref_mem[8'h20]);
    tick(); idle_inputs(); #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL rmw_readback: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
    checks++; if (writes_seen - wbase !== 1) begin errors++; $display("FAIL rmw_write_count: got %0d expected 1", writes_seen - wbase); end
  endtask

  task automatic test_full_zero_writes();
    tick(); resp_ready = 1'b1; wbase = writes_seen;
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'h30; req_data = 32'hCAFEF00D; req_byte_en = 4'b1111; #1;
    checks++; if (bram_writeEnable !== 1'b1 || bram_writeAddress !== 8'h30 || bram_writeData !== 32'hCAFEF00D || bram_readEnable !== 1'b0) begin
      errors++; $display("FAIL full_write: got wen=%b wa=%h wd=%h ren=%b expected 1 30 cafef00d 0", bram_writeEnable, bram_writeAddress, bram_writeData, bram_readEnable); end
    ref_mem[8'h30] = 32'hCAFEF00D;
    tick(); req_address = 8'h31; req_data = 32'h55555555; req_byte_en = 4'b0000; #1;
    checks++; if (bram_writeEnable !== 1'b0 || bram_readEnable !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL zero_write: got wen=%b ren=%b rdy=%b expected 0 0 1", bram_writeEnable, bram_readEnable, req_ready); end
    tick(); req_write = 1'b0; req_address = 8'h30; req_byte_en = 4'h0; #1;
    exp_q.push_back(ref_mem[8'h30]);
    tick(); req_address = 8'h31; #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL full_readback: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
    exp_q.push_back(ref_mem[8'h31]);
    tick(); idle_inputs(); #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL zero_readback: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
    checks++; if (writes_seen - wbase !== 1) begin errors++; $display("FAIL full_zero_count: got %0d expected 1", writes_seen - wbase); end
  endtask

  task automatic test_reset_mid_rmw();
    tick(); resp_ready = 1'b1; wbase = writes_seen;
    req_valid = 1'b1; req_write = 1'b1; req_address = 8'h40; req_data = 32'hFFFFFFFF; req_byte_en = 4'b0011;
    tick(); idle_inputs(); reset = 1'b0; #1;
    checks++; if (bram_writeEnable !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rmw_reset: got wen=%b rdy=%b expected 0 0", bram_writeEnable, req_ready); end
    tick(); reset = 1'b1; #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || bram_writeEnable !== 1'b0) begin
      errors++; $display("FAIL mid_rmw_idle: got v=%b rdy=%b wen=%b expected 0 1 0", resp_valid, req_ready, bram_writeEnable); end
`ifdef BRAM_CTRL_COUNTERS_EN
    checks++; if (read_count !== 32'd0 || write_count !== 32'd0) begin
      errors++; $display("FAIL mid_rmw_counters: got %0d/%0d expected 0/0", read_count, write_count); end
`endif
    tick(); tick();
    req_valid = 1'b1; req_write = 1'b0; req_address = 8'h40; #1;
    exp_q.push_back(ref_mem[8'h40]);
    tick(); idle_inputs(); #1;
    exp_v = exp_q.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_data !== exp_v) begin
      errors++; $display("FAIL mid_rmw_data: got v=%b d=%h expected 1 %h", resp_valid, resp_data, exp_v); end
    checks++; if (writes_seen !== wbase) begin errors++; $display("FAIL mid_rmw_nowrite: got %0d expected %0d", writes_seen, wbase); end
  endtask

  initial begin
    errors = 0; checks = 0; writes_seen = 0;
    bram_readData = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a] = $urandom;
      ref_mem[a] = mem[a];
    end
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    mem[8'h05] = 32'h12345678; ref_mem[8'h05] = 32'h12345678;
    mem[8'h20] = 32'hAABBCCDD; ref_mem[8'h20] = 32'hAABBCCDD;
    mem[8'h31] = 32'h0BADC0DE; ref_mem[8'h31] = 32'h0BADC0DE;
    mem[8'h40] = 32'h01020304; ref_mem[8'h40] = 32'h01020304;

    test_reset();
    test_read_latency();
    test_back_to_back();
    test_backpressure();
    test_rmw();
    test_full_zero_writes();
    test_reset_mid_rmw();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_request_controller.md
Name: bram_request_controller

Overview:
- Initiator side of the BRAM read/write port interface. Sits between a core or cache memory stage and one BRAM instance.
- Accepts word requests from the core over a valid/ready handshake and drives the BRAM read and write ports.
- Absorbs the BRAM's one-cycle read latency and returns read data over a valid/ready response channel.
- Implements byte-masked writes as read-modify-write.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; matches the attached BRAM.
- BE_WIDTH, DATA_WIDTH/8, localparam, byte-enable width.

Ports:
- clock  in  1  single clock; every flop is on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data.
- req_byte_en  in  BE_WIDTH  write byte mask; ignored for reads.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  DATA_WIDTH  read data.
- bram_readEnable  out  1  to BRAM readEnable.
- bram_readAddress  out  ADDR_WIDTH  to BRAM readAddress.
- bram_readData  in  DATA_WIDTH  from BRAM; valid one cycle after readEnable.
- bram_writeEnable  out  1  to BRAM writeEnable.
- bram_writeAddress  out  ADDR_WIDTH  to BRAM writeAddress.
- bram_writeData  out  DATA_WIDTH  to BRAM writeData.

Behaviour:
- Handshake: a request is accepted when req_valid & req_ready. A response transfers when resp_valid & resp_ready.
- States: IDLE, READ_WAIT, RESP_HOLD, RMW_READ, RMW_WRITE.
- Reset (reset==0): state IDLE; resp_valid=0; resp_data=0; hold, merge and address registers cleared.
  - req_ready=0 and both BRAM enables=0 while reset is low.
  - Reset in any state abandons the operation: no write is issued and the held response is dropped.
- BRAM outputs are combinational from the request in the accept cycle and from registered state otherwise.
  - Enables are 0 in every cycle not listed below.
  - Read and write are never issued in the same cycle, so the BRAM's same-address forwarding path is never exercised.
- IDLE: req_ready=1.
  - Accepted read: bram_readEnable=1, bram_readAddress=req_address; next state READ_WAIT.
  - Accepted write with req_byte_en all ones: bram_writeEnable=1 with req_address/req_data in the same cycle; stay IDLE; no response.
  - Accepted write with req_byte_en zero: no BRAM access; stay IDLE.
  - Accepted write with a partial mask: latch address, data and mask; bram_readEnable=1 on that address; next state RMW_READ.
- READ_WAIT: resp_valid=1, resp_data=bram_readData (combinational pass-through, latency 1).
  - If resp_ready: req_ready=1, and a new request is handled exactly as in IDLE, so back-to-back reads sustain 1 per cycle. With no new request, next state IDLE.
  - If !resp_ready: capture bram_readData into the hold register; req_ready=0; next state RESP_HOLD.
- RESP_HOLD: resp_valid=1, resp_data=hold register; req_ready=0. Hold data stays stable until resp_ready, then next state IDLE.
- RMW_READ: merge per byte, i: merged[i] = mask[i] ? wdata[i] : bram_readData[i]. Register the result; req_ready=0; next state RMW_WRITE.
- RMW_WRITE: bram_writeEnable=1 with the latched address and merged word; req_ready=0; next state IDLE.
  - A partial write costs 3 cycles from acceptance to IDLE.
- Ordering: requests complete in acceptance order. A read following an RMW observes the merged data because the write lands before the next accept.
- Address is word-granular with no wrap logic; the full ADDR_WIDTH range is valid.

Optional Feature:
- Macro: BRAM_CTRL_COUNTERS_EN.
- Defined: adds output ports read_count [31:0] and write_count [31:0].
  - read_count increments on each accepted read.
  - write_count increments on each BRAM write issued (a full write or an RMW_WRITE; a zero-mask write does not count).
  - Both saturate at 32'hFFFFFFFF and clear to 0 on reset.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Package bram_ctrl_pkg:
  - state encoding constants ST_IDLE=0, ST_READ_WAIT=1, ST_RESP_HOLD=2, ST_RMW_READ=3, ST_RMW_WRITE=4 (3 bits);
  - the counter width constant CNT_WIDTH=32.
- One sub-module, bram_byte_merge: combinational per-byte mux of the write data over the read data under the mask, parameterized by DATA_WIDTH.
- The testbench instantiates the controller with the existing BRAM as the memory model.

Test Plan:
- Read latency: BRAM[0x10]=32'hDEADBEEF; read 0x10 with resp_ready=1 -> resp_valid high the next cycle with resp_data=32'hDEADBEEF, then state IDLE.
- Back-to-back reads: reads of 0x01, 0x02, 0x03 on consecutive cycles with resp_ready=1 -> req_ready held 1, three consecutive responses with matching data, no bubbles.
- Backpressure: read 0x05 (data 32'h12345678) with resp_ready=0 for 4 cycles -> resp_data stable at 32'h12345678, req_ready=0 throughout, single transfer when resp_ready rises.
- RMW: BRAM[0x20]=32'hAABBCCDD; write 32'h11223344 with mask 4'b0101 -> one read then one write; read-back of 0x20 gives 32'hAA22CC44.
- Full and zero-mask writes: mask 4'b1111 with 32'hCAFEF00D to 0x30 -> single write cycle, read-back gives 32'hCAFEF00D. Mask 4'b0000 -> no bram_writeEnable pulse and data unchanged.
- Reset mid-RMW: assert reset in RMW_READ -> no write to the address, resp_valid=0 and state IDLE after release; with BRAM_CTRL_COUNTERS_EN defined, the counters read 0.
